// File: rtl/regfile_write_arbiter_if.sv
// Register file write arbiter bus interface.
//
// Bundles the CPU writeback request, the I/O valid/ready write request and the
// registered register-file write port into one interface.
//   master : drives cpu_we/cpu_writeReg/cpu_data and io_valid/io_writeReg/io_data,
//            observes cpu_stall, io_ready, the write port and fifo_count.
//   slave  : the arbiter side (the inverse directions).
// FIFO_DEPTH only sizes fifo_count and must match the arbiter instance.
interface regfile_write_arbiter_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    // CPU writeback source
    logic                          cpu_we;
    logic [4:0]                    cpu_writeReg;
    logic [31:0]                   cpu_data;
    logic                          cpu_stall;

    // I/O writer source
    logic                          io_valid;
    logic [4:0]                    io_writeReg;
    logic [31:0]                   io_data;
    logic                          io_ready;

    // Register file write port
    logic                          ctrl_writeEnable;
    logic [4:0]                    ctrl_writeReg;
    logic [31:0]                   data_writeReg;

    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output cpu_we, cpu_writeReg, cpu_data,
        output io_valid, io_writeReg, io_data,
        input  cpu_stall, io_ready,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  fifo_count
    );

    modport slave (
        input  cpu_we, cpu_writeReg, cpu_data,
        input  io_valid, io_writeReg, io_data,
        output cpu_stall, io_ready,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output fifo_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register file write arbiter.
//
// Sole driver of the register file write port. Merges the CPU writeback stage
// (normally highest priority) with an external I/O writer whose requests are
// buffered in a FIFO_DEPTH-entry FIFO. When the FIFO head has lost arbitration
// MAX_WAIT consecutive cycles, the CPU is stalled for one cycle and the head is
// forced through. The write port is registered (one cycle latency).
//
// Ports:
//   clock       : system clock, rising edge.
//   ctrl_reset  : asynchronous active-low reset.
//   bus (slave) : cpu_we/cpu_writeReg/cpu_data in, cpu_stall out (combinational);
//                 io_valid/io_writeReg/io_data in, io_ready out;
//                 ctrl_writeEnable/ctrl_writeReg/data_writeReg out (registered);
//                 fifo_count out (occupied FIFO entries).
module regfile_write_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,  // power of two, >= 2
    parameter int unsigned MAX_WAIT   = 8   // >= 1
) (
    input logic                    clock,
    input logic                    ctrl_reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } entry_t;

    // FIFO storage and bookkeeping
    entry_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wait_q, wait_d;

    // Registered write port
    logic            we_q, we_d;
    logic [4:0]      reg_q, reg_d;
    logic [31:0]     data_q, data_d;

    logic            fifo_empty;
    logic            fifo_full;
    logic            starve;
    logic            push;
    logic            pop;
    entry_t          head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign head       = mem_q[rd_ptr_q];
    assign starve     = (wait_q == WAIT_LIMIT) && !fifo_empty;

    // io_ready looks only at "full", never at a same-cycle pop.
    assign bus.io_ready  = ctrl_reset & ~fifo_full;
    assign bus.cpu_stall = ctrl_reset & starve;
    assign push          = bus.io_valid & bus.io_ready;

    // Arbitration and next-state for the write port and wait counter
    always_comb begin
        we_d   = 1'b0;
        reg_d  = reg_q;
        data_d = data_q;
        wait_d = wait_q;
        pop    = 1'b0;
        if (starve) begin
            pop    = 1'b1;
            we_d   = |head.wreg;
            reg_d  = head.wreg;
            data_d = head.wdata;
            wait_d = '0;
        end else if (bus.cpu_we) begin
            // r0 writes are still "issued", just with the enable suppressed.
            we_d   = |bus.cpu_writeReg;
            reg_d  = bus.cpu_writeReg;
            data_d = bus.cpu_data;
            if (fifo_empty) begin
                wait_d = '0;
            end else if (wait_q != WAIT_LIMIT) begin
                wait_d = wait_q + 1'b1;
            end
        end else if (!fifo_empty) begin
            pop    = 1'b1;
            we_d   = |head.wreg;
            reg_d  = head.wreg;
            data_d = head.wdata;
            wait_d = '0;
        end else begin
            wait_d = '0;
        end
    end

    // FIFO pointer/count next-state; pointers wrap since depth is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            we_q     <= 1'b0;
            reg_q    <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{wreg: bus.io_writeReg, wdata: bus.io_data};
        end
    end

    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = reg_q;
    assign bus.data_writeReg    = data_q;
    assign bus.fifo_count       = count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (FIFO_DEPTH=4, MAX_WAIT=8).
module tb_regfile_write_arbiter;
    logic clock;
    logic ctrl_reset;
    int   n_total;
    int   n_bad;

    regfile_write_arbiter_if #(.FIFO_DEPTH(4)) bus ();

    regfile_write_arbiter #(
        .FIFO_DEPTH (4),
        .MAX_WAIT   (8)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] wreg,
                              input logic [31:0] wdata);
        check_eq({tag, ".we"},   64'(bus.ctrl_writeEnable), 64'(we));
        check_eq({tag, ".reg"},  64'(bus.ctrl_writeReg),    64'(wreg));
        check_eq({tag, ".data"}, 64'(bus.data_writeReg),    64'(wdata));
    endtask

    logic [4:0]  exp_reg [5];
    logic [31:0] exp_dat [5];
    logic [2:0]  exp_cnt [5];

    initial begin
        n_total = 0;
        n_bad   = 0;

        // ---------------- Reset with requests pending ----------------
        ctrl_reset       = 1'b0;
        bus.cpu_we       = 1'b1;
        bus.cpu_writeReg = 5'd9;
        bus.cpu_data     = 32'h1111_1111;
        bus.io_valid     = 1'b1;
        bus.io_writeReg  = 5'd8;
        bus.io_data      = 32'h2222_2222;
        #1;
        step();
        step();
        check_port("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst.io_ready",  64'(bus.io_ready),   64'd0);
        check_eq("rst.cpu_stall", 64'(bus.cpu_stall),  64'd0);
        check_eq("rst.count",     64'(bus.fifo_count), 64'd0);
        bus.cpu_we   = 1'b0;
        bus.io_valid = 1'b0;
        ctrl_reset   = 1'b1;
        step();
        check_eq("rel.io_ready", 64'(bus.io_ready),   64'd1);
        check_eq("rel.count",    64'(bus.fifo_count), 64'd0);
        check_port("rel", 1'b0, 5'd0, 32'd0);

        // ---------------- CPU only ----------------
        bus.cpu_we       = 1'b1;
        bus.cpu_writeReg = 5'd5;
        bus.cpu_data     = 32'hDEAD_BEEF;
        #1;
        check_eq("cpu.stall", 64'(bus.cpu_stall), 64'd0);
        step();
        check_port("cpu5", 1'b1, 5'd5, 32'hDEAD_BEEF);
        bus.cpu_writeReg = 5'd0;
        bus.cpu_data     = 32'h1234_5678;
        step();
        check_port("cpu0", 1'b0, 5'd0, 32'h1234_5678);
        bus.cpu_we = 1'b0;
        step();
        check_port("hold", 1'b0, 5'd0, 32'h1234_5678);

        // ---------------- I/O only: latency 2 ----------------
        bus.io_valid    = 1'b1;
        bus.io_writeReg = 5'd1;
        bus.io_data     = 32'h0000_0003;
        #1;
        check_eq("io.ready", 64'(bus.io_ready), 64'd1);
        step();
        bus.io_valid = 1'b0;
        check_eq("io.c1.we",    64'(bus.ctrl_writeEnable), 64'd0);
        check_eq("io.c1.count", 64'(bus.fifo_count),       64'd1);
        step();
        check_port("io.c2", 1'b1, 5'd1, 32'h0000_0003);
        check_eq("io.c2.count", 64'(bus.fifo_count), 64'd0);

        // I/O write to r0: popped, enable suppressed
        bus.io_valid    = 1'b1;
        bus.io_writeReg = 5'd0;
        bus.io_data     = 32'h0000_0055;
        step();
        bus.io_valid = 1'b0;
        step();
        check_port("io.r0", 1'b0, 5'd0, 32'h0000_0055);
        check_eq("io.r0.count", 64'(bus.fifo_count), 64'd0);

        // ---------------- Fill to full under CPU traffic ----------------
        bus.cpu_we       = 1'b1;
        bus.cpu_writeReg = 5'd2;
        bus.cpu_data     = 32'h0000_00C0;
        for (int i = 0; i < 4; i++) begin
            bus.io_valid    = 1'b1;
            bus.io_writeReg = 5'(10 + i);
            bus.io_data     = 32'hA0 + 32'(i);
            #1;
            check_eq($sformatf("fill%0d.ready", i), 64'(bus.io_ready), 64'd1);
            step();
            check_port($sformatf("fill%0d", i), 1'b1, 5'd2, 32'h0000_00C0);
        end
        bus.io_writeReg = 5'd14;
        bus.io_data     = 32'hA4;
        #1;
        check_eq("full.count", 64'(bus.fifo_count), 64'd4);
        check_eq("full.ready", 64'(bus.io_ready),   64'd0);
        step();
        check_eq("full.hold.count", 64'(bus.fifo_count), 64'd4);
        check_eq("full.hold.ready", 64'(bus.io_ready),   64'd0);

        // Drain in order; fifth push lands on the cycle after the first pop
        bus.cpu_we = 1'b0;
        exp_reg[0] = 5'd10; exp_dat[0] = 32'hA0; exp_cnt[0] = 3'd3;
        exp_reg[1] = 5'd11; exp_dat[1] = 32'hA1; exp_cnt[1] = 3'd3;
        exp_reg[2] = 5'd12; exp_dat[2] = 32'hA2; exp_cnt[2] = 3'd2;
        exp_reg[3] = 5'd13; exp_dat[3] = 32'hA3; exp_cnt[3] = 3'd1;
        exp_reg[4] = 5'd14; exp_dat[4] = 32'hA4; exp_cnt[4] = 3'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) bus.io_valid = 1'b0;
            check_port($sformatf("drain%0d", i), 1'b1, exp_reg[i], exp_dat[i]);
            check_eq($sformatf("drain%0d.count", i), 64'(bus.fifo_count), 64'(exp_cnt[i]));
        end
        step();
        check_eq("drained.we", 64'(bus.ctrl_writeEnable), 64'd0);

        // ---------------- Starvation ----------------
        bus.cpu_we       = 1'b1;
        bus.cpu_writeReg = 5'd3;
        bus.cpu_data     = 32'h0000_0033;
        bus.io_valid     = 1'b1;
        bus.io_writeReg  = 5'd7;
        bus.io_data      = 32'h0000_0077;
        step();
        bus.io_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_eq($sformatf("starve.k%0d.stall", k), 64'(bus.cpu_stall), 64'd0);
            step();
            check_port($sformatf("starve.k%0d", k), 1'b1, 5'd3, 32'h0000_0033);
        end
        check_eq("starve.stall", 64'(bus.cpu_stall), 64'd1);
        step();
        check_port("starve.io", 1'b1, 5'd7, 32'h0000_0077);
        check_eq("starve.after.stall", 64'(bus.cpu_stall),  64'd0);
        check_eq("starve.after.count", 64'(bus.fifo_count), 64'd0);
        step();
        check_port("starve.cpu", 1'b1, 5'd3, 32'h0000_0033);

        // ---------------- Idle CPU gaps drain the FIFO ----------------
        bus.cpu_writeReg = 5'd4;
        bus.cpu_data     = 32'h0000_0044;
        bus.io_valid     = 1'b1;
        bus.io_writeReg  = 5'd20;
        bus.io_data      = 32'h0000_2020;
        step();
        bus.io_writeReg  = 5'd21;
        bus.io_data      = 32'h0000_2121;
        step();
        bus.io_valid = 1'b0;
        check_eq("gap.count", 64'(bus.fifo_count), 64'd2);
        bus.cpu_we = 1'b0;
        step();
        check_port("gap.io0", 1'b1, 5'd20, 32'h0000_2020);
        bus.cpu_we = 1'b1;
        #1;
        check_eq("gap.stall", 64'(bus.cpu_stall), 64'd0);
        step();
        check_port("gap.cpu", 1'b1, 5'd4, 32'h0000_0044);
        bus.cpu_we = 1'b0;
        step();
        check_port("gap.io1", 1'b1, 5'd21, 32'h0000_2121);
        check_eq("gap.count.end", 64'(bus.fifo_count), 64'd0);

        // ---------------- Reset mid-operation ----------------
        bus.cpu_we       = 1'b1;
        bus.cpu_writeReg = 5'd6;
        bus.cpu_data     = 32'h0000_0066;
        bus.io_valid     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.io_writeReg = 5'(24 + i);
            bus.io_data     = 32'hB0 + 32'(i);
            step();
        end
        bus.io_valid = 1'b0;
        step();
        step();
        step();
        check_eq("mid.count", 64'(bus.fifo_count), 64'd3);
        ctrl_reset = 1'b0;
        #1;
        check_port("mid.rst", 1'b0, 5'd0, 32'd0);
        check_eq("mid.rst.count", 64'(bus.fifo_count), 64'd0);
        check_eq("mid.rst.ready", 64'(bus.io_ready),   64'd0);
        check_eq("mid.rst.stall", 64'(bus.cpu_stall),  64'd0);
        bus.cpu_we = 1'b0;
        step();
        ctrl_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("mid.post%0d.we", i),    64'(bus.ctrl_writeEnable), 64'd0);
            check_eq($sformatf("mid.post%0d.count", i), 64'(bus.fifo_count),       64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
